// File: rtl/tag_pkg.sv
// Shared types and constants for the 2-way, 64-set tag store controller.
package tag_pkg;

   localparam int ADDR_W    = 32;
   localparam int SET_W     = 6;
   localparam int OFF_W     = 4;
   localparam int WORD_LEN  = 32;
   localparam int TAG_W     = ADDR_W - SET_W - OFF_W;
   localparam int VALID_BIT = 31;
   localparam int NUM_SETS  = 1 << SET_W;
   localparam int FCNT_W    = SET_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      CMP,
      MREQ,
      MWAIT,
      FILL,
      FLUSH
   } state_t;

   // Valid bit set, tag in the low bits, everything else zero.
   function automatic logic [WORD_LEN-1:0] make_tag_word(input logic [TAG_W-1:0] tag);
      logic [WORD_LEN-1:0] word;
      word               = '0;
      word[VALID_BIT]    = 1'b1;
      word[TAG_W-1:0]    = tag;
      return word;
   endfunction

endpackage

// File: rtl/tag_ctrl_if.sv
// Request/response, refill and tag SRAM signals of the tag controller.
// master = controller side, slave = front end / memory side / SRAM.
interface tag_ctrl_if import tag_pkg::*; ();

   logic                req_valid;
   logic                req_ready;
   logic [ADDR_W-1:0]   req_addr;
   logic                rsp_valid;
   logic                rsp_hit;
   logic                rsp_way;
   logic                refill_valid;
   logic                refill_ready;
   logic [ADDR_W-1:0]   refill_addr;
   logic                refill_done;
   logic                flush;
   logic                flush_busy;
   logic                sram_ce;
   logic                sram_web;
   logic                sram_oeb;
   logic                sram_bank;
   logic [SET_W-1:0]    sram_addr;
   logic [WORD_LEN-1:0] sram_wdata;
   logic [WORD_LEN-1:0] sram_rdata;

   modport master (
      input  req_valid, req_addr, refill_ready, refill_done, flush, sram_rdata,
      output req_ready, rsp_valid, rsp_hit, rsp_way, refill_valid, refill_addr,
             flush_busy, sram_ce, sram_web, sram_oeb, sram_bank, sram_addr, sram_wdata
   );

   modport slave (
      output req_valid, req_addr, refill_ready, refill_done, flush, sram_rdata,
      input  req_ready, rsp_valid, rsp_hit, rsp_way, refill_valid, refill_addr,
             flush_busy, sram_ce, sram_web, sram_oeb, sram_bank, sram_addr, sram_wdata
   );

endinterface

// File: rtl/tag_lru.sv
// 64x1 LRU bit file: each bit names the way to evict next in its set.
module tag_lru import tag_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             upd_en,
   input  logic             upd_val,
   input  logic [SET_W-1:0] set,
   output logic             rd_val
);

   logic [NUM_SETS-1:0] lru_reg;

   generate
      for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_bit
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               lru_reg[gi] <= 1'b0;
            else if (clear)
               lru_reg[gi] <= 1'b0;
            else if (upd_en && set == SET_W'(gi))
               lru_reg[gi] <= upd_val;
         end
      end
   endgenerate

   assign rd_val = lru_reg[set];

endmodule

// File: rtl/tag_ctrl.sv
// Tag store sequencer: lookup, victim choice, refill handshake, tag install, flush.
// Optional TAG_AUTO_FLUSH_EN: invalidate the whole array right after reset release.
module tag_ctrl import tag_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   tag_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   state_t              state_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [WORD_LEN-1:0] tag0_reg;
   logic                victim_reg;
   logic [FCNT_W-1:0]   cnt_reg;

   logic                req_ready_reg;
   logic                rsp_valid_reg;
   logic                rsp_hit_reg;
   logic                rsp_way_reg;
   logic                refill_valid_reg;
   logic [ADDR_W-1:0]   refill_addr_reg;
   logic                flush_busy_reg;
   logic                sram_ce_reg;
   logic                sram_web_reg;
   logic                sram_oeb_reg;
   logic                sram_bank_reg;
   logic [SET_W-1:0]    sram_addr_reg;
   logic [WORD_LEN-1:0] sram_wdata_reg;

   logic [SET_W-1:0]    set_idx;
   logic [TAG_W-1:0]    tag_val;
   logic [WORD_LEN-1:0] want_word;
   logic [FCNT_W-1:0]   cnt_inc;
   logic                hit0;
   logic                hit1;
   logic                start_flush;
   logic                lru_clear;
   logic                lru_upd_en;
   logic                lru_upd_val;
   logic                lru_rd;

`ifdef TAG_AUTO_FLUSH_EN
   logic init_reg;
   assign start_flush = bus.flush | init_reg;
`else
   assign start_flush = bus.flush;
`endif

   assign set_idx   = addr_reg[OFF_W +: SET_W];
   assign tag_val   = addr_reg[ADDR_W-1 -: TAG_W];
   assign want_word = make_tag_word(tag_val);
   assign cnt_inc   = cnt_reg + 1'b1;

   // Only make_tag_word() or zero is ever written, so a full-word compare is
   // the same as valid && tag match.
   assign hit0 = (tag0_reg == want_word);
   assign hit1 = (bus.sram_rdata == want_word);

   assign lru_clear   = (state_reg == IDLE) && start_flush;
   assign lru_upd_en  = ((state_reg == CMP) && (hit0 || hit1)) || (state_reg == FILL);
   assign lru_upd_val = (state_reg == FILL) ? ~victim_reg : hit0;

   tag_lru u_lru (
      .clk     (clk),
      .rst     (rst),
      .clear   (lru_clear),
      .upd_en  (lru_upd_en),
      .upd_val (lru_upd_val),
      .set     (set_idx),
      .rd_val  (lru_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         addr_reg         <= '0;
         tag0_reg         <= '0;
         victim_reg       <= 1'b0;
         cnt_reg          <= '0;
         req_ready_reg    <= 1'b0;
         rsp_valid_reg    <= 1'b0;
         rsp_hit_reg      <= 1'b0;
         rsp_way_reg      <= 1'b0;
         refill_valid_reg <= 1'b0;
         refill_addr_reg  <= '0;
         flush_busy_reg   <= 1'b0;
         sram_ce_reg      <= 1'b0;
         sram_web_reg     <= 1'b1;
         sram_oeb_reg     <= 1'b1;
         sram_bank_reg    <= 1'b0;
         sram_addr_reg    <= '0;
         sram_wdata_reg   <= '0;
`ifdef TAG_AUTO_FLUSH_EN
         init_reg         <= 1'b1;
`endif
      end else begin
         // Outputs describe the next state's cycle; the SRAM idles unless a
         // transition below starts an access.
         rsp_valid_reg <= 1'b0;
         sram_ce_reg   <= 1'b0;
         sram_web_reg  <= 1'b1;
         sram_oeb_reg  <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (start_flush) begin
                  state_reg      <= FLUSH;
                  req_ready_reg  <= 1'b0;
                  flush_busy_reg <= 1'b1;
                  cnt_reg        <= '0;
                  sram_ce_reg    <= 1'b1;
                  sram_web_reg   <= 1'b0;
                  sram_bank_reg  <= 1'b0;
                  sram_addr_reg  <= '0;
                  sram_wdata_reg <= '0;
               end else if (bus.req_valid && req_ready_reg) begin
                  state_reg     <= RD0;
                  req_ready_reg <= 1'b0;
                  addr_reg      <= bus.req_addr & LINE_MASK;
                  sram_ce_reg   <= 1'b1;
                  sram_oeb_reg  <= 1'b0;
                  sram_bank_reg <= 1'b0;
                  sram_addr_reg <= bus.req_addr[OFF_W +: SET_W];
               end else begin
                  req_ready_reg <= 1'b1;
               end
            end

            RD0: begin
               state_reg     <= RD1;
               sram_ce_reg   <= 1'b1;
               sram_oeb_reg  <= 1'b0;
               sram_bank_reg <= 1'b1;
            end

            RD1: begin
               tag0_reg  <= bus.sram_rdata;
               state_reg <= CMP;
            end

            CMP: begin
               if (hit0 || hit1) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_hit_reg   <= 1'b1;
                  rsp_way_reg   <= ~hit0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  if (!tag0_reg[VALID_BIT])
                     victim_reg <= 1'b0;
                  else if (!bus.sram_rdata[VALID_BIT])
                     victim_reg <= 1'b1;
                  else
                     victim_reg <= lru_rd;
                  refill_valid_reg <= 1'b1;
                  refill_addr_reg  <= addr_reg;
                  state_reg        <= MREQ;
               end
            end

            MREQ: begin
               if (bus.refill_ready) begin
                  refill_valid_reg <= 1'b0;
                  state_reg        <= MWAIT;
               end
            end

            MWAIT: begin
               if (bus.refill_done) begin
                  state_reg      <= FILL;
                  sram_ce_reg    <= 1'b1;
                  sram_web_reg   <= 1'b0;
                  sram_bank_reg  <= victim_reg;
                  sram_addr_reg  <= set_idx;
                  sram_wdata_reg <= want_word;
                  rsp_valid_reg  <= 1'b1;
                  rsp_hit_reg    <= 1'b0;
                  rsp_way_reg    <= victim_reg;
               end
            end

            FILL: begin
               req_ready_reg <= 1'b1;
               state_reg     <= IDLE;
            end

            FLUSH: begin
               if (cnt_reg == '1) begin
                  flush_busy_reg <= 1'b0;
                  req_ready_reg  <= 1'b1;
                  state_reg      <= IDLE;
               end else begin
                  cnt_reg        <= cnt_inc;
                  sram_ce_reg    <= 1'b1;
                  sram_web_reg   <= 1'b0;
                  sram_bank_reg  <= cnt_inc[0];
                  sram_addr_reg  <= cnt_inc[FCNT_W-1:1];
                  sram_wdata_reg <= '0;
               end
            end

            default: state_reg <= IDLE;
         endcase

`ifdef TAG_AUTO_FLUSH_EN
         if (state_reg == IDLE)
            init_reg <= 1'b0;
`endif
      end
   end

   assign bus.req_ready    = req_ready_reg;
   assign bus.rsp_valid    = rsp_valid_reg;
   assign bus.rsp_hit      = rsp_hit_reg;
   assign bus.rsp_way      = rsp_way_reg;
   assign bus.refill_valid = refill_valid_reg;
   assign bus.refill_addr  = refill_addr_reg;
   assign bus.flush_busy   = flush_busy_reg;
   assign bus.sram_ce      = sram_ce_reg;
   assign bus.sram_web     = sram_web_reg;
   assign bus.sram_oeb     = sram_oeb_reg;
   assign bus.sram_bank    = sram_bank_reg;
   assign bus.sram_addr    = sram_addr_reg;
   assign bus.sram_wdata   = sram_wdata_reg;

endmodule
